// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial checker: self-seeds from the incoming stream,
// verifies a run of correct predictions, then counts bit errors while locked.
module prbs31_checker #(
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 64,
    parameter int WIN      = 256,
    parameter int LOSS_ERR = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int LERR_W = (LOSS_ERR > 1) ? $clog2(LOSS_ERR) : 1;

    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [LERR_W-1:0] LOSS_LAST = LERR_W'(LOSS_ERR - 1);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [30:0]        h_q, h_d;
    logic [4:0]         seed_cnt_q, seed_cnt_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [LERR_W-1:0]  win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic        pred;
    logic        miss;
    logic        win_wrap;
    logic [30:0] h_din;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement can infer a latch.
        state_d     = state_q;
        h_d         = h_q;
        seed_cnt_d  = seed_cnt_q;
        good_cnt_d  = good_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;

        pred     = h_q[27] ^ h_q[30];
        miss     = din ^ pred;
        win_wrap = (win_cnt_q == WIN_LAST);
        h_din    = {h_q[29:0], din};

        if (en) begin
            unique case (state_q)
                SEED: begin
                    h_d = h_din;
                    if (seed_cnt_q == 5'd30) begin
                        seed_cnt_d = '0;
                        // An all-zero history is the LFSR lock-up state; reseed.
                        if (h_din != '0) begin
                            state_d    = VERIFY;
                            good_cnt_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                VERIFY: begin
                    h_d = h_din;
                    if (miss) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                        good_cnt_d = '0;
                    end else if (good_cnt_q == LOCK_LAST) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // Free-running predictor: a corrupted bit never enters h,
                    // so it costs exactly one error.
                    h_d       = {h_q[29:0], pred};
                    win_cnt_d = win_wrap ? '0 : win_cnt_q + 1'b1;
                    if (miss) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
                        if (win_err_q == LOSS_LAST) begin
                            state_d    = SEED;
                            seed_cnt_d = '0;
                            win_cnt_d  = '0;
                            win_err_d  = '0;
                        end else begin
                            win_err_d = win_wrap ? '0 : win_err_q + 1'b1;
                        end
                    end else if (win_wrap) begin
                        win_err_d = '0;
                    end
                end
                default: state_d = SEED;
            endcase
        end

        if (clr_err) err_cnt_d = '0;
        locked_d = (state_d == LOCKED);
    end

    // NOTE: this reset is active-high despite its name; it matches the rest of
    // the chip and acts asynchronously.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= SEED;
            h_q         <= '0;
            seed_cnt_q  <= '0;
            good_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            seed_cnt_q  <= seed_cnt_d;
            good_cnt_q  <= good_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: default instance plus a 4-bit counter
// instance for saturation, clear priority and asynchronous reset.
module tb_prbs31_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, en1, din1, clr1, locked1, pulse1;
    logic [15:0] cnt1;
    logic rst2, en2, din2, clr2, locked2, pulse2;
    logic [3:0] cnt2;

    prbs31_checker u_dut1 (
        .clk(clk), .rst_n(rst1), .en(en1), .din(din1), .clr_err(clr1),
        .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1)
    );

    prbs31_checker #(.ERR_W(4), .LOSS_ERR(8)) u_dut2 (
        .clk(clk), .rst_n(rst2), .en(en2), .din(din2), .clr_err(clr2),
        .locked(locked2), .err_pulse(pulse2), .err_cnt(cnt2)
    );

    int checks   = 0;
    int failures = 0;
    bit sel      = 1'b0;
    logic [30:0] g;
    int n_locked;

    logic        locked_m, pulse_m;
    logic [15:0] cnt_m;
    assign locked_m = sel ? locked2 : locked1;
    assign pulse_m  = sel ? pulse2 : pulse1;
    assign cnt_m    = sel ? {12'd0, cnt2} : cnt1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference generator, seed 1: each new bit is g[27] ^ g[30].
    function automatic logic gen();
        logic b;
        b = g[27] ^ g[30];
        g = {g[29:0], b};
        return b;
    endfunction

    task automatic step(input logic e, input logic d, input logic c);
        @(negedge clk);
        if (sel) begin en2 = e; din2 = d; clr2 = c; end
        else     begin en1 = e; din1 = d; clr1 = c; end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        if (sel) begin rst2 = 1'b1; en2 = 1'b0; clr2 = 1'b0; end
        else     begin rst1 = 1'b1; en1 = 1'b0; clr1 = 1'b0; end
        repeat (2) @(negedge clk);
        if (sel) rst2 = 1'b0; else rst1 = 1'b0;
        g = 31'd1;
        n_locked = 0;
    endtask

    // Feed clean bits until lock; checks lock timing at 94/95 accepted samples.
    task automatic acquire(input string tag);
        for (int i = 1; i <= 95; i++) begin
            step(1'b1, gen(), 1'b0);
            if (i == 94) check({tag, "_before"}, locked_m, 0);
        end
        check({tag, "_after"}, locked_m, 1);
        n_locked = 0;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, gen(), 1'b0);
            n_locked++;
        end
    endtask

    task automatic flip(input logic c);
        step(1'b1, ~gen(), c);
        n_locked++;
    endtask

    initial begin
        int pulses;
        int acc;
        bit seen;
        rst1 = 1'b1; en1 = 1'b0; din1 = 1'b0; clr1 = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; din2 = 1'b0; clr2 = 1'b0;
        g = 31'd1;
        n_locked = 0;

        // Reset state and clean lock on the default instance.
        sel = 1'b0;
        do_reset();
        @(posedge clk); #1;
        check("reset_locked", locked1, 0);
        check("reset_pulse", pulse1, 0);
        check("reset_cnt", cnt1, 0);
        acquire("lock");

        pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, gen(), 1'b0);
            n_locked++;
            if (pulse1) pulses++;
        end
        check("clean_pulses", pulses, 0);
        check("clean_cnt", cnt1, 0);
        check("clean_locked", locked1, 1);

        // Single flipped bit, then en=0 with garbage din freezes everything.
        flip(1'b0);
        check("flip_pulse", pulse1, 1);
        check("flip_cnt", cnt1, 1);
        step(1'b0, 1'b1, 1'b0);
        check("hold_pulse", pulse1, 0);
        check("hold_cnt", cnt1, 1);
        check("hold_locked", locked1, 1);
        pulses = 0;
        for (int i = 0; i < 31; i++) begin
            clean(1);
            if (pulse1) pulses++;
        end
        check("flip_tail_pulses", pulses, 0);
        check("flip_tail_cnt", cnt1, 1);
        check("flip_tail_locked", locked1, 1);

        // Clear the counter, then 8 errors in one window force loss of lock.
        step(1'b1, gen(), 1'b1);
        n_locked++;
        check("clr_cnt", cnt1, 0);
        check("clr_locked", locked1, 1);
        while (n_locked % 256 != 0) clean(1);
        for (int k = 1; k <= 8; k++) begin
            flip(1'b0);
            if (k == 7) check("loss_7th_locked", locked1, 1);
            if (k < 8) clean(5);
        end
        check("loss_8th_locked", locked1, 0);
        check("loss_cnt", cnt1, 8);
        acquire("relock");
        check("relock_cnt", cnt1, 8);

        // Random en at ~50% duty must match the continuous run per accepted sample.
        do_reset();
        acc = 0;
        for (int i = 0; i < 2000 && acc < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, gen(), 1'b0);
                acc++;
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            check("rand_locked", locked1, (acc >= 95) ? 1 : 0);
            check("rand_pulse", pulse1, 0);
        end
        check("rand_cnt", cnt1, 0);

        // Stuck-at inputs never lock.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            seen = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                step(1'b1, 1'(v), 1'b0);
                if (locked1) seen = 1'b1;
            end
            check(v ? "stuck1_locked" : "stuck0_locked", seen, 0);
            check(v ? "stuck1_cnt" : "stuck0_cnt", cnt1, 0);
        end

        // 4-bit counter instance: saturation, clear priority, async reset.
        sel = 1'b1;
        do_reset();
        acquire("w4_lock");
        for (int k = 1; k <= 20; k++) begin
            clean(99);
            flip(1'b0);
            if (k == 15) check("w4_cnt_15", cnt2, 15);
        end
        check("w4_sat_cnt", cnt2, 15);
        check("w4_sat_locked", locked2, 1);
        clean(10);
        flip(1'b1);
        check("w4_clr_cnt", cnt2, 0);
        check("w4_clr_pulse", pulse2, 1);
        check("w4_clr_locked", locked2, 1);
        #1 rst2 = 1'b1;
        #1;
        check("w4_arst_locked", locked2, 0);
        check("w4_arst_pulse", pulse2, 0);
        check("w4_arst_cnt", cnt2, 0);
        @(negedge clk);
        rst2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
